// File: rtl/battle_fsm.sv
// battle_fsm: top-level battle sequencer (MENU -> DODGE -> ACTION -> ATTACK -> RESULT).
// Owns page/substage, player and monster HP, the shared page timer, action-menu
// selection and the movement instruction decode for the player sprite.
// Optional feature: define HIT_IFRAME_EN to ignore further hits for IFRAME_CYCLES
// cycles after an applied hit.
module battle_fsm #(
  parameter int unsigned HP_W          = 8,
  parameter int unsigned MON_HP_MAX    = 100,
  parameter int unsigned PLAYER_HP_MAX = 20,
  parameter int unsigned HEAL_AMT      = 5,
  parameter int unsigned N_ACTIONS     = 4,
  parameter int unsigned DODGE_CYCLES  = 1000000,
  parameter int unsigned ATK_TIMEOUT   = 500000,
  parameter int unsigned IFRAME_CYCLES = 50000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      keyboard,
  input  logic            is_hit,
  input  logic [HP_W-1:0] hit_dmg,
  input  logic            atk_pass,
  input  logic [HP_W-1:0] dmg_mon,
  output logic [7:0]      state,
  output logic [15:0]     player_instruction,
  output logic            is_move,
  output logic [HP_W-1:0] mon_hp,
  output logic [HP_W-1:0] player_hp
);

  // One timer width covers the dodge turn, the attack timeout and the i-frame window.
  localparam int unsigned TmrMax01 = (DODGE_CYCLES > ATK_TIMEOUT) ? DODGE_CYCLES : ATK_TIMEOUT;
  localparam int unsigned TmrMax   = (TmrMax01 > IFRAME_CYCLES) ? TmrMax01 : IFRAME_CYCLES;
  localparam int unsigned TW       = $clog2(TmrMax + 1);

  localparam logic [TW-1:0] DodgeLast = TW'(DODGE_CYCLES - 1);
  localparam logic [TW-1:0] AtkLast   = TW'(ATK_TIMEOUT - 1);
  localparam logic [3:0]    SelLast   = 4'(N_ACTIONS - 1);

  localparam logic [3:0] KeyW     = 4'd1;
  localparam logic [3:0] KeyD     = 4'd2;
  localparam logic [3:0] KeyS     = 4'd3;
  localparam logic [3:0] KeyA     = 4'd4;
  localparam logic [3:0] KeySpace = 4'd5;

  typedef enum logic [3:0] {
    PgMenu   = 4'h1,
    PgResult = 4'h2,
    PgDodge  = 4'h9,
    PgAttack = 4'hA,
    PgAction = 4'hB
  } page_e;

  page_e           page_q, page_d;
  logic [3:0]      sub_q, sub_d;
  logic [HP_W-1:0] php_q, php_d;
  logic [HP_W-1:0] mhp_q, mhp_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [15:0]     instr_q, instr_d;
  logic            move_q, move_d;
  logic [3:0]      prev_q;

  logic            press;
  logic            hit_apply;
  logic [HP_W-1:0] php_hit;
  logic [HP_W:0]   heal_sum;
  logic [HP_W-1:0] php_heal;
  logic [HP_W-1:0] mhp_atk;

  assign press    = (keyboard != 4'd0) && (keyboard != prev_q);
  assign php_hit  = (hit_dmg >= php_q) ? '0 : php_q - hit_dmg;
  assign heal_sum = {1'b0, php_q} + (HP_W + 1)'(HEAL_AMT);
  assign php_heal = (heal_sum > (HP_W + 1)'(PLAYER_HP_MAX)) ? HP_W'(PLAYER_HP_MAX)
                                                            : heal_sum[HP_W-1:0];
  assign mhp_atk  = (dmg_mon >= mhp_q) ? '0 : mhp_q - dmg_mon;

`ifdef HIT_IFRAME_EN
  logic [TW-1:0] ifr_q, ifr_d;

  assign hit_apply = is_hit && (ifr_q == '0);

  // Invulnerability countdown; only runs while staying in DODGE.
  always_comb begin
    ifr_d = '0;
    if (page_q == PgDodge && page_d == PgDodge) begin
      if (ifr_q != '0)  ifr_d = ifr_q - 1'b1;
      else if (is_hit)  ifr_d = TW'(IFRAME_CYCLES);
    end
  end

  // I-frame counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ifr_q <= '0;
    else       ifr_q <= ifr_d;
  end
`else
  assign hit_apply = is_hit;
`endif

  // Next-state, HP arithmetic and movement decode.
  always_comb begin
    page_d  = page_q;
    sub_d   = sub_q;
    php_d   = php_q;
    mhp_d   = mhp_q;
    instr_d = 16'h0000;
    move_d  = 1'b0;

    case (page_q)
      PgMenu: begin
        if (press && keyboard == KeySpace) begin
          page_d = PgDodge;
          sub_d  = 4'd0;
          php_d  = HP_W'(PLAYER_HP_MAX);
          mhp_d  = HP_W'(MON_HP_MAX);
        end
      end
      PgDodge: begin
        if (keyboard >= KeyW && keyboard <= KeyA) begin
          instr_d = {4'h5, keyboard - 4'd1, 8'h00};
          move_d  = 1'b1;
        end
        if (hit_apply) php_d = php_hit;
        // Death is checked first so a lethal hit beats the turn timeout.
        if (php_d == '0) begin
          page_d = PgResult;
          sub_d  = 4'd2;
        end else if (timer_q == DodgeLast) begin
          page_d = PgAction;
          sub_d  = 4'd0;
        end
      end
      PgAction: begin
        if (press) begin
          if (keyboard == KeyD) begin
            sub_d = (sub_q == SelLast) ? 4'd0 : sub_q + 4'd1;
          end else if (keyboard == KeyA) begin
            sub_d = (sub_q == 4'd0) ? SelLast : sub_q - 4'd1;
          end else if (keyboard == KeySpace) begin
            sub_d = 4'd0;
            if (sub_q == 4'd0) begin
              page_d = PgAttack;
            end else begin
              if (sub_q == 4'd1) php_d = php_heal;
              page_d = PgDodge;
            end
          end
        end
      end
      PgAttack: begin
        if (atk_pass) begin
          mhp_d = mhp_atk;
          if (mhp_atk == '0) begin
            page_d = PgResult;
            sub_d  = 4'd1;
          end else begin
            page_d = PgDodge;
            sub_d  = 4'd0;
          end
        end else if (timer_q == AtkLast) begin
          page_d = PgDodge;
          sub_d  = 4'd0;
        end
      end
      PgResult: begin
        if (press && keyboard == KeySpace) begin
          page_d = PgMenu;
          sub_d  = 4'd0;
        end
      end
      default: begin
        page_d = PgMenu;
        sub_d  = 4'd0;
      end
    endcase

    // Shared page timer: clears on every page change, counts only on timed pages.
    if (page_d != page_q)                           timer_d = '0;
    else if (page_q == PgDodge || page_q == PgAttack) timer_d = timer_q + 1'b1;
    else                                             timer_d = '0;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      page_q  <= PgMenu;
      sub_q   <= 4'd0;
      php_q   <= '0;
      mhp_q   <= '0;
      timer_q <= '0;
      instr_q <= 16'h0000;
      move_q  <= 1'b0;
      prev_q  <= 4'd0;
    end else begin
      page_q  <= page_d;
      sub_q   <= sub_d;
      php_q   <= php_d;
      mhp_q   <= mhp_d;
      timer_q <= timer_d;
      instr_q <= instr_d;
      move_q  <= move_d;
      prev_q  <= keyboard;
    end
  end

  assign state              = {page_q, sub_q};
  assign player_instruction = instr_q;
  assign is_move            = move_q;
  assign mon_hp             = mhp_q;
  assign player_hp          = php_q;

endmodule

// File: doc/battle_fsm.md
Name: battle_fsm

Overview:
- Parametrised top-level battle sequencer for the game: MENU -> DODGE -> ACTION -> ATTACK loop with a RESULT screen.
- Owns page/substage state, player and monster HP, the dodge turn timer, action-menu selection and movement instruction decode for the player sprite.
- Sits between the keyboard decoder and the render/bullet/attack-bar blocks.
- Adds over the previous generation: configurable HP widths and limits, timed dodge turns, a player-HP model, a selectable action menu, attack timeout and saturating arithmetic.

Parameters:
- HP_W, 8, width of all HP and damage buses.
- MON_HP_MAX, 100, monster HP loaded at battle start.
- PLAYER_HP_MAX, 20, player HP loaded at battle start; ceiling for healing.
- HEAL_AMT, 5, HP restored by the HEAL action.
- N_ACTIONS, 4, number of action-menu entries (2..16).
- DODGE_CYCLES, 1000000, clock cycles per dodge turn.
- ATK_TIMEOUT, 500000, cycles the ATTACK page waits for atk_pass.
- IFRAME_CYCLES, 50000, invulnerability window; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- keyboard  in  4  key code: 0 none, 1 W, 2 D, 3 S, 4 A, 5 SPACE.
- is_hit  in  1  bullet collision this cycle.
- hit_dmg  in  HP_W  damage applied on is_hit.
- atk_pass  in  1  attack bar finished (1-cycle pulse).
- dmg_mon  in  HP_W  damage dealt to the monster, valid with atk_pass.
- state  out  8  {page[3:0], substage[3:0]}.
- player_instruction  out  16  {op[3:0], dir[3:0], 8'h00}.
- is_move  out  1  valid movement instruction present.
- mon_hp  out  HP_W  remaining monster HP.
- player_hp  out  HP_W  remaining player HP.

Behaviour:
- Page codes: MENU 4'h1, RESULT 4'h2, DODGE 4'h9, ATTACK 4'hA, ACTION 4'hB. Any other page returns to MENU/0 on the next clock.
- Reset (async assert, synchronous release): state = {MENU,0}; player_instruction = 0; is_move = 0; mon_hp = 0; player_hp = 0; timers = 0.
- All outputs are registered with 1-cycle latency from input to output.
- Key press = keyboard != 0 and keyboard != previous-cycle keyboard. The previous-cycle register clears to 0 on reset. Menu navigation and SPACE act on presses only.
- MENU: SPACE press -> {DODGE,0}; load mon_hp = MON_HP_MAX and player_hp = PLAYER_HP_MAX; clear the turn timer.
- DODGE, movement:
  - Keyboard is level-decoded every cycle: W -> {4'h5,4'd0}, D -> {4'h5,4'd1}, S -> {4'h5,4'd2}, A -> {4'h5,4'd3}, each followed by 8'h00, with is_move = 1.
  - Any other key -> instruction 0, is_move = 0.
  - player_instruction and is_move are forced to 0 on every page except DODGE.
- DODGE, damage: on is_hit, player_hp = max(player_hp - hit_dmg, 0), saturating.
- DODGE, timer: increments each cycle. When it reaches DODGE_CYCLES-1, go to {ACTION,0} and clear the timer.
- DODGE, death: player_hp reaching 0 -> {RESULT,2} (lose). A lethal hit in the same cycle as timer expiry resolves as lose.
- ACTION: substage = selection index.
  - D press increments the index, A press decrements it, modulo N_ACTIONS (wrap both ways).
  - SPACE press on index 0 (FIGHT) -> {ATTACK,0}.
  - SPACE press on index 1 (HEAL): player_hp = min(player_hp + HEAL_AMT, PLAYER_HP_MAX), computed HP_W+1 wide; then -> {DODGE,0}.
  - SPACE press on any other index (MERCY/ITEM placeholders) -> {DODGE,0}.
- ATTACK:
  - On atk_pass: mon_hp = max(mon_hp - dmg_mon, 0). Result 0 -> {RESULT,1} (win); otherwise -> {DODGE,0}.
  - With no atk_pass for ATK_TIMEOUT cycles -> {DODGE,0}, mon_hp unchanged.
  - Timer clears on page entry.
- RESULT: HP values are held. SPACE press -> {MENU,0}.
- Reset asserted mid-battle returns immediately to the reset values; no partial HP update survives.

Optional Feature:
- Macro: HIT_IFRAME_EN.
- Defined: after an applied hit, further is_hit is ignored for IFRAME_CYCLES cycles. The counter clears on reset and on leaving DODGE.
- Undefined: every cycle with is_hit high deducts hit_dmg.

Test Plan:
- Bench parameters: DODGE_CYCLES=16, ATK_TIMEOUT=8, N_ACTIONS=4.
- Reset then hold SPACE 5 cycles -> single transition to state 8'h90; mon_hp=100, player_hp=20; no retrigger while held.
- In DODGE, keyboard=1 -> next cycle player_instruction=16'h5000, is_move=1. keyboard=4 -> 16'h5300. keyboard=0 -> 16'h0000, is_move=0. After 16 cycles -> state 8'hB0.
- In ACTION press A once -> state 8'hB3 (wrap). Press D twice -> 8'hB1. SPACE with player_hp=17 -> player_hp=20 (saturated), state 8'h90.
- In ATTACK with mon_hp=30, pulse atk_pass with dmg_mon=45 -> mon_hp=0, state 8'h21. SPACE -> 8'h10.
- player_hp=3, is_hit with hit_dmg=7 in the cycle the timer expires -> player_hp=0, state 8'h22 (lose beats timeout).
- Without HIT_IFRAME_EN, is_hit high 3 cycles with hit_dmg=2 -> player_hp 20 to 14. With HIT_IFRAME_EN and IFRAME_CYCLES=10 -> 18. No atk_pass for 8 cycles in ATTACK -> 8'h90, mon_hp unchanged.
